// File: rtl/vscale_np_hasti_sram_if.sv
// HASTI (AHB-Lite) bus bundle for an NPORTS-wide slave; port i occupies slice i
// of every vector field.
interface vscale_np_hasti_sram_if #(
  parameter int NPORTS = 2
);
  logic [32*NPORTS-1:0] haddr;
  logic [NPORTS-1:0]    hwrite;
  logic [3*NPORTS-1:0]  hsize;
  logic [3*NPORTS-1:0]  hburst;
  logic [NPORTS-1:0]    hmastlock;
  logic [4*NPORTS-1:0]  hprot;
  logic [2*NPORTS-1:0]  htrans;
  logic [32*NPORTS-1:0] hwdata;
  logic [32*NPORTS-1:0] hrdata;
  logic [NPORTS-1:0]    hready;
  logic [NPORTS-1:0]    hresp;

  modport master (
    output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_np_hasti_sram.sv
// Multi-port HASTI SRAM: byte-lane writes from every port, one commit per cycle
// (lowest port wins), cross-port read forwarding. VSCALE_SRAM_RANGE_CHECK_EN adds ERROR responses.
//   state    | meaning
//   ST_IDLE  | no data phase on this port
//   ST_READ  | read data phase, always completes this cycle
//   ST_WRITE | write data phase, completes when granted the commit slot
//   ST_ERR1  | first ERROR cycle (hready low)
//   ST_ERR2  | second ERROR cycle (hready high)
module vscale_np_hasti_sram #(
  parameter int NWORDS = 1024,
  parameter int NPORTS = 2
) (
  input logic                   hclk,
  input logic                   hreset,
  vscale_np_hasti_sram_if.slave bus
);

  localparam int AW = $clog2(NWORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ERR1,
    ST_ERR2
  } pstate_t;

  pstate_t           st_q    [NPORTS];
  pstate_t           st_d    [NPORTS];
  logic [AW+1:0]     daddr_q [NPORTS];
  logic [2:0]        dsize_q [NPORTS];
  logic [AW-1:0]     idx     [NPORTS];
  logic [3:0]        mask    [NPORTS];

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] ready;
  logic [NPORTS-1:0] accept;
  logic [NPORTS-1:0] oor;

  logic [31:0]       mem [NWORDS];

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;
  logic [31:0]       wr_bm;
  logic [31:0]       rd_word;

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] lut;
    case (size)
      3'd0:    lut = 4'h1;
      3'd1:    lut = 4'h3;
      default: lut = 4'hf;
    endcase
    return lut << off;
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < NPORTS; i++) begin
      idx[i]  = daddr_q[i][AW+1:2];
      mask[i] = byte_mask(dsize_q[i], daddr_q[i][1:0]);
      req[i]  = (st_q[i] == ST_WRITE);
    end
  end

  // Fixed priority: the first requester in index order owns the single write slot.
  always_comb begin
    grant   = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_mask = '0;
    wr_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (req[i] && !wr_en) begin
        grant[i] = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = idx[i];
        wr_mask  = mask[i];
        wr_data  = bus.hwdata[32*i +: 32];
      end
    end
  end

  assign wr_bm = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};

`ifdef VSCALE_SRAM_RANGE_CHECK_EN
  localparam logic [31:0] NW32 = 32'(NWORDS);
`endif

  always_comb begin
    ready  = '0;
    accept = '0;
    oor    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      case (st_q[i])
        ST_WRITE: ready[i] = grant[i];
        ST_ERR1:  ready[i] = 1'b0;
        default:  ready[i] = 1'b1;
      endcase
      accept[i] = ready[i] & bus.htrans[2*i+1];
`ifdef VSCALE_SRAM_RANGE_CHECK_EN
      oor[i] = ({2'b00, bus.haddr[32*i+2 +: 30]} >= NW32);
`else
      oor[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      st_d[i] = st_q[i];
      if (st_q[i] == ST_ERR1) begin
        st_d[i] = ST_ERR2;
      end else if (ready[i]) begin
        if (!accept[i])          st_d[i] = ST_IDLE;
        else if (oor[i])         st_d[i] = ST_ERR1;
        else if (bus.hwrite[i])  st_d[i] = ST_WRITE;
        else                     st_d[i] = ST_READ;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i]    <= ST_IDLE;
        daddr_q[i] <= '0;
        dsize_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i] <= st_d[i];
        if (accept[i]) begin
          daddr_q[i] <= bus.haddr[32*i +: AW+2];
          dsize_q[i] <= bus.hsize[3*i +: 3];
        end
      end
    end
  end

`ifndef SYNTHESIS
  initial begin
    for (int w = 0; w < NWORDS; w++) mem[w] = 32'h0;
  end
`endif

  always_ff @(posedge hclk) begin
    if (wr_en) mem[wr_idx] <= (mem[wr_idx] & ~wr_bm) | (wr_data & wr_bm);
  end

  // Reads see the word as it will be after this cycle's commit.
  always_comb begin
    bus.hrdata = '0;
    rd_word    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      rd_word = mem[idx[i]];
      if (wr_en && (wr_idx == idx[i])) rd_word = (rd_word & ~wr_bm) | (wr_data & wr_bm);
      if (st_q[i] == ST_READ) bus.hrdata[32*i +: 32] = rd_word;
    end
  end

  assign bus.hready = ready;

`ifdef VSCALE_SRAM_RANGE_CHECK_EN
  always_comb begin
    bus.hresp = '0;
    for (int i = 0; i < NPORTS; i++) begin
      bus.hresp[i] = (st_q[i] == ST_ERR1) || (st_q[i] == ST_ERR2);
    end
  end
`else
  assign bus.hresp = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot, bus.htrans, bus.haddr};

endmodule

// File: tb/tb_vscale_np_hasti_sram.sv
// Randomised scoreboard bench for vscale_np_hasti_sram: a cycle-level driver feeds a
// word-array reference model that pushes expected responses; a monitor pops and compares.
module tb_vscale_np_hasti_sram;
  localparam int NP = 2;
  localparam int NW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vscale_np_hasti_sram_if #(.NPORTS(NP)) bus ();

  vscale_np_hasti_sram #(.NWORDS(NW), .NPORTS(NP)) dut (
    .hclk  (clk),
    .hreset(rst),
    .bus   (bus)
  );

  typedef struct {
    int          kind;   // 0 idle, 1 read, 2 write
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  op_t  opq  [NP][$];
  exp_t expq [NP][$];

  // per-port data phase: 0 none, 1 read, 2 write, 3 error cycle 1, 4 error cycle 2
  int          dp_kind [NP];
  logic [31:0] dp_addr [NP];
  logic [2:0]  dp_size [NP];
  logic [31:0] dp_data [NP];
  logic [31:0] mdl [NW];

  bit          pend_v;
  logic [31:0] pend_addr;
  logic [2:0]  pend_size;
  logic [31:0] pend_data;

  int total = 0;
  int bad   = 0;

  function automatic int widx(logic [31:0] a);
    return int'({2'b00, a[31:2]}) % NW;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] a, logic [2:0] sz,
                                        logic [31:0] d);
    logic [31:0] r;
    int off, n;
    r   = old;
    off = int'(a[1:0]);
    n   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic op_t mk(int kind, logic [31:0] addr, logic [2:0] size, logic [31:0] data);
    op_t o;
    o.kind = kind; o.addr = addr; o.size = size; o.data = data;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int w, off;
    o.kind = int'($urandom_range(0, 2));
    o.size = 3'($urandom_range(0, 2));
    w      = int'($urandom_range(0, 15));
    case (o.size)
      3'd0:    off = int'($urandom_range(0, 3));
      3'd1:    off = 2 * int'($urandom_range(0, 1));
      default: off = 0;
    endcase
    o.addr = 32'(w * 4 + off);
    o.data = $urandom;
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic drive_op(int i, op_t o);
    bus.haddr[32*i +: 32] = o.addr;
    bus.hwrite[i]         = (o.kind == 2);
    bus.hsize[3*i +: 3]   = o.size;
    bus.htrans[2*i +: 2]  = (o.kind == 0) ? 2'b00 : 2'b10;
  endtask

  // Called just after each rising edge: models the cycle that edge started.
  task automatic step();
    int gi;
    exp_t e;
    op_t o;
    logic [31:0] w;
    if (pend_v) mdl[widx(pend_addr)] = merge(mdl[widx(pend_addr)], pend_addr, pend_size, pend_data);
    pend_v = 1'b0;
    gi = -1;
    for (int i = 0; i < NP; i++) if (dp_kind[i] == 2 && gi < 0) gi = i;
    for (int i = 0; i < NP; i++) bus.hwdata[32*i +: 32] = (dp_kind[i] == 2) ? dp_data[i] : 32'h0;
    if (gi >= 0) begin
      pend_v = 1'b1; pend_addr = dp_addr[gi]; pend_size = dp_size[gi]; pend_data = dp_data[gi];
    end
    for (int i = 0; i < NP; i++) begin
      e.rdy = 1'b1; e.resp = 1'b0; e.rdata = 32'h0;
      case (dp_kind[i])
        1: begin
          w = mdl[widx(dp_addr[i])];
          if (pend_v && widx(pend_addr) == widx(dp_addr[i])) w = merge(w, pend_addr, pend_size, pend_data);
          e.rdata = w;
        end
        2: e.rdy = (i == gi);
        3: begin e.rdy = 1'b0; e.resp = 1'b1; end
        4: e.resp = 1'b1;
        default: ;
      endcase
      expq[i].push_back(e);
      if (dp_kind[i] == 3) begin
        dp_kind[i] = 4;
      end else if (e.rdy) begin
        o = (opq[i].size() > 0) ? opq[i].pop_front() : mk(0, 32'h0, 3'd0, 32'h0);
        drive_op(i, o);
        dp_kind[i] = o.kind; dp_addr[i] = o.addr; dp_size[i] = o.size; dp_data[i] = o.data;
`ifdef VSCALE_SRAM_RANGE_CHECK_EN
        if (o.kind != 0 && {2'b00, o.addr[31:2]} >= 32'(NW)) dp_kind[i] = 3;
`endif
      end
    end
  endtask

  task automatic run_drain(int maxc);
    int c;
    bit busy;
    c = 0;
    do begin
      @(posedge clk); #1;
      step();
      c++;
      busy = 1'b0;
      for (int i = 0; i < NP; i++) if (opq[i].size() > 0 || dp_kind[i] != 0) busy = 1'b1;
    end while (busy && c < maxc);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL drain timeout after %0d cycles", c);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (expq[i].size() > 0) e = expq[i].pop_front();
        else begin e.rdy = 1'b1; e.resp = 1'b0; e.rdata = 32'h0; end
        chk($sformatf("p%0d hready", i), 32'(bus.hready[i]), 32'(e.rdy));
        chk($sformatf("p%0d hresp", i),  32'(bus.hresp[i]),  32'(e.resp));
        chk($sformatf("p%0d hrdata", i), bus.hrdata[32*i +: 32], e.rdata);
      end
    end
  end

  initial begin : driver
    bus.haddr = '0; bus.hwrite = '0; bus.hsize = '0; bus.hburst = '0;
    bus.hmastlock = '0; bus.hprot = '0; bus.htrans = '0; bus.hwdata = '0;
    for (int i = 0; i < NP; i++) begin
      dp_kind[i] = 0; dp_addr[i] = '0; dp_size[i] = '0; dp_data[i] = '0;
    end
    for (int w = 0; w < NW; w++) mdl[w] = 32'h0;
    pend_v = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // byte lane write merged into a full word
    opq[0].push_back(mk(2, 32'h10, 3'd2, 32'hAABBCCDD));
    opq[0].push_back(mk(2, 32'h12, 3'd0, 32'h00110000));
    opq[0].push_back(mk(1, 32'h10, 3'd2, 32'h0));
    run_drain(50);

    // same-cycle write collision on word 4
    opq[0].push_back(mk(2, 32'h10, 3'd2, 32'h1));
    opq[0].push_back(mk(0, 32'h0, 3'd0, 32'h0));
    opq[0].push_back(mk(1, 32'h10, 3'd2, 32'h0));
    opq[1].push_back(mk(2, 32'h10, 3'd2, 32'h2));
    run_drain(50);

    // p1 read forwarded from p0 commit
    opq[0].push_back(mk(2, 32'h20, 3'd2, 32'hDEADBEEF));
    opq[1].push_back(mk(1, 32'h20, 3'd2, 32'h0));
    run_drain(50);

    // write then back-to-back read, plus simultaneous cross-port read
    opq[0].push_back(mk(2, 32'h0C, 3'd2, 32'h5));
    opq[0].push_back(mk(1, 32'h0C, 3'd2, 32'h0));
    opq[1].push_back(mk(1, 32'h0C, 3'd2, 32'h0));
    run_drain(50);

    // out-of-range write: ERROR with the range check, wraps to word 0 without it
    opq[0].push_back(mk(2, 32'h1000, 3'd2, 32'h77777777));
    opq[0].push_back(mk(1, 32'h0, 3'd2, 32'h0));
    opq[1].push_back(mk(0, 32'h0, 3'd0, 32'h0));
    opq[1].push_back(mk(0, 32'h0, 3'd0, 32'h0));
    opq[1].push_back(mk(0, 32'h0, 3'd0, 32'h0));
    opq[1].push_back(mk(1, 32'h0, 3'd2, 32'h0));
    run_drain(50);

    // reset in the middle of a p1 write stall
    opq[0].push_back(mk(2, 32'h54, 3'd2, 32'h12345678));
    run_drain(20);
    opq[0].push_back(mk(2, 32'h50, 3'd2, 32'hA5A5A5A5));
    opq[1].push_back(mk(2, 32'h54, 3'd2, 32'h0BADF00D));
    @(posedge clk); #1; step();
    @(posedge clk); #1; step();
    #2 rst = 1'b1;
    for (int i = 0; i < NP; i++) begin
      expq[i].delete();
      opq[i].delete();
      dp_kind[i] = 0;
      drive_op(i, mk(0, 32'h0, 3'd0, 32'h0));
    end
    pend_v = 1'b0;
    #1;
    chk("rst hready", 32'(bus.hready), 32'h3);
    chk("rst hresp", 32'(bus.hresp), 32'h0);
    chk("rst hrdata0", bus.hrdata[31:0], 32'h0);
    chk("rst hrdata1", bus.hrdata[63:32], 32'h0);
    @(negedge clk) rst = 1'b0;
    opq[0].push_back(mk(1, 32'h54, 3'd2, 32'h0));
    opq[0].push_back(mk(1, 32'h50, 3'd2, 32'h0));
    opq[1].push_back(mk(1, 32'h54, 3'd2, 32'h0));
    run_drain(20);

    // randomised traffic over a small address window to force collisions
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < NP; i++) opq[i].push_back(rnd_op());
    run_drain(5000);

    for (int w = 0; w < 16; w++) opq[w % NP].push_back(mk(1, 32'(4 * w), 3'd2, 32'h0));
    run_drain(100);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
